mdu_sequencer: RTL
==================

# mdu_sequencer

Multiply/divide unit sequencer for the five-stage pipeline. It sits in the E stage, accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo operations, and models multi-cycle latency with a `busy` counter. It owns the HI/LO registers and drives the `start`/`busy` pair that hazard control uses to stall any MDU instruction in D.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `MDUOp`  in  4: E-stage op. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo. Codes 9–15 are treated as none.
- `start`  in  1: E-stage pulse that launches a mult/div. Must be high only with op 1–4.
- `A`  in  32: rs operand, after forwarding.
- `B`  in  32: rt operand, after forwarding.
- `busy`  out  1: a mult/div is in flight.
- `HI_out`  out  32: architectural HI.
- `LO_out`  out  32: architectural LO.
- `MDU_out`  out  32: HI_out when MDUOp=5, LO_out when MDUOp=6, else 0. Combinational.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter `cnt` active.
- Launch:
  - Condition: IDLE, `start`=1, MDUOp ∈ {1..4}.
  - Latch the result into pending registers P_HI/P_LO.
  - Load `cnt` = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
- RUN:
  - `cnt` decrements each cycle.
  - When `cnt`==1, at that edge: HI←P_HI, LO←P_LO, go to IDLE.
- Arithmetic:
  - mult: signed 32×32 → 64. HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32 → 64, same split.
  - div: LO = signed quotient (truncated toward zero), HI = remainder (sign follows dividend A).
  - divu: unsigned quotient and remainder.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0), div or divu: occupies the full DIV_CYCLES, then HI/LO unchanged.
- mthi/mtlo:
  - When IDLE and MDUOp=7 (8), HI (LO) ← A at the clock edge. Needs no `start`.
  - Ignored while busy.
- Ignored requests:
  - `start` while busy: ignored, no restart, no state change.
  - `start` with op ∉ {1..4}: ignored.
- mfhi/mflo never alter state.
- HI/LO are not observable until commit; during RUN, HI_out/LO_out hold old values.

## Timing
- Reset (asynchronous): busy=0, HI=0, LO=0, P_HI=P_LO=0, cnt=0, state IDLE. MDU_out then follows the 0 registers.
- `start` high in cycle t (mult) → busy=1 in cycles t+1..t+MULT_CYCLES. New HI/LO visible and busy=0 from cycle t+MULT_CYCLES+1.
- div: same pattern with DIV_CYCLES.
- Back-to-back: a new `start` is accepted in the first cycle busy=0 after commit.
- mthi/mtlo in cycle t → HI_out/LO_out updated in t+1.
- Reset asserted mid-RUN: operation aborted and nothing committed. Outputs reach reset values immediately, without waiting for an edge.
- Hazard-control contract: any D-stage MDU op stalls while `start|busy`. The block still tolerates violations by ignoring them as specified above.

## Structure
- Package `mdu_pkg`:
  - op-code localparams (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MFHI, MDU_MFLO, MDU_MTHI, MDU_MTLO);
  - state encoding (IDLE, RUN);
  - default latency constants.
- Sub-module `mdu_calc`: combinational 64-bit result generator (op, A, B → hi, lo, div_by_zero). The sequencer holds only the FSM, the counter, and the pending and architectural registers.

## Test plan
- Reset then mult: A=0xFFFFFFFE (−2), B=3, start in cycle 1.
  - busy high cycles 2–6.
  - Cycle 7: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - MDUOp=6 → MDU_out=0xFFFFFFFA.
- divu and div:
  - divu A=7, B=2 → after 10 busy cycles LO=3, HI=1.
  - div A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: HI=0x11, LO=0x22 preset via mthi/mtlo, then div B=0.
  - busy 10 cycles.
  - HI/LO remain 0x11/0x22.
- Ignored inputs during a mult's RUN: `start` with divu and mtlo A=0x55.
  - Both ignored; busy ends on the original schedule.
  - LO = mult result, not 0x55.
- Reset mid-division at busy cycle 4:
  - busy=0, HI=LO=0 immediately.
  - No later commit.
- Back-to-back: multu 0xFFFFFFFF×0xFFFFFFFF, then start again in the first idle cycle.
  - First commit HI=0xFFFFFFFE, LO=0x00000001.
  - Second run accepted with no idle gap.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and default latencies for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_launch_op(input logic [3:0] op);
    return (op >= MDU_MULT) && (op <= MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit mult/div result generator feeding the sequencer's pending registers.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic signed [63:0] a_s;
  logic signed [63:0] b_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign a_s    = {{32{a[31]}}, a};
  assign b_s    = {{32{b[31]}}, b};
  assign prod_s = a_s * b_s;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so INT_MIN / -1 wraps to INT_MIN with rem 0
  assign a_neg   = (op == MDU_DIV) && a[31];
  assign b_neg   = (op == MDU_DIV) && b[31];
  assign a_mag   = a_neg ? (32'd0 - a) : a;
  assign b_mag   = b_neg ? (32'd0 - b) : b;
  assign divisor = (b == 32'd0) ? 32'd1 : b_mag;
  assign q_mag   = a_mag / divisor;
  assign r_mag   = a_mag % divisor;
  assign quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = a_neg ? (32'd0 - r_mag) : r_mag;

  assign div_by_zero = is_div_op(op) && (b == 32'd0);

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (op)
      MDU_MULT: begin
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        hi = rem;
        lo = quot;
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage MDU sequencer: owns HI/LO, models mult/div latency with a busy counter.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI_out,
  output logic [31:0] LO_out,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      p_hi;
  logic [31:0]      p_lo;

  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_dz;
  logic        launch;

  mdu_calc u_calc (
    .op          (MDUOp),
    .a           (A),
    .b           (B),
    .hi          (calc_hi),
    .lo          (calc_lo),
    .div_by_zero (calc_dz)
  );

  assign launch = (state == IDLE) && start && is_launch_op(MDUOp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            // Divide by zero re-commits the current HI/LO, leaving them unchanged
            p_hi  <= calc_dz ? hi_q : calc_hi;
            p_lo  <= calc_dz ? lo_q : calc_lo;
            cnt   <= is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state <= RUN;
          end else if (MDUOp == MDU_MTHI) begin
            hi_q <= A;
          end else if (MDUOp == MDU_MTLO) begin
            lo_q <= A;
          end
        end
        RUN: begin
          if (cnt == CNT_W'(1)) begin
            hi_q  <= p_hi;
            lo_q  <= p_lo;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy   = (state == RUN);
  assign HI_out = hi_q;
  assign LO_out = lo_q;

  always_comb begin
    MDU_out = 32'd0;
    case (MDUOp)
      MDU_MFHI: MDU_out = hi_q;
      MDU_MFLO: MDU_out = lo_q;
      default:  MDU_out = 32'd0;
    endcase
  end

endmodule
